// File: rtl/fifo_slot_tracker_if.sv
// Place/consume/flush handshake and occupancy status between the FIFO
// write/read logic and the slot tracker.
interface fifo_slot_tracker_if #(
    parameter int ADDRWIDTH = 8
);
    localparam int FIFODEPTH = 2 ** ADDRWIDTH;

    logic                 place_valid;
    logic [ADDRWIDTH-1:0] place_addr;
    logic                 consume_valid;
    logic [ADDRWIDTH-1:0] consume_addr;
    logic                 flush_req;
    logic                 err_clear;

    logic [FIFODEPTH-1:0] slot_unused;
    logic [ADDRWIDTH:0]   occupancy;
    logic                 empty;
    logic                 full;
    logic                 almost_full;
    logic                 place_allow;
    logic [ADDRWIDTH-1:0] next_rd_addr;
    logic                 rd_slot_ready;
    logic                 flush_done;
    logic                 err_overflow;
    logic                 err_underflow;
    logic                 err_sequence;

    modport master (
        output place_valid, place_addr, consume_valid, consume_addr, flush_req, err_clear,
        input  slot_unused, occupancy, empty, full, almost_full, place_allow,
               next_rd_addr, rd_slot_ready, flush_done,
               err_overflow, err_underflow, err_sequence
    );

    modport slave (
        input  place_valid, place_addr, consume_valid, consume_addr, flush_req, err_clear,
        output slot_unused, occupancy, empty, full, almost_full, place_allow,
               next_rd_addr, rd_slot_ready, flush_done,
               err_overflow, err_underflow, err_sequence
    );
endinterface

// File: rtl/fifo_slot_tracker.sv
// Slot-occupancy bitmap, count and flags for the clock-crossing FIFO RAM;
// checks gray ordering of place/consume events and sequences flushes.
module fifo_slot_tracker #(
    parameter int ADDRWIDTH          = 8,
    parameter int ALMOST_FULL_MARGIN = 10
) (
    input  logic                srff_clock,
    input  logic                srff_aresetn,
    fifo_slot_tracker_if.slave  bus
);
    localparam int FIFODEPTH = 2 ** ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] AF_THRESH = (ADDRWIDTH+1)'(FIFODEPTH - ALMOST_FULL_MARGIN);
    localparam logic [ADDRWIDTH:0] FULL_CNT  = (ADDRWIDTH+1)'(FIFODEPTH);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH, ST_FLUSH_DONE} state_t;

    state_t                 state_q, state_d;
    logic [FIFODEPTH-1:0]   slot_q, slot_d, slot_after_cons;
    logic [ADDRWIDTH:0]     occ_q, occ_d;
    logic [ADDRWIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDRWIDTH-1:0]   wr_exp_q, wr_exp_d;
    logic                   empty_q, full_q, afull_q, allow_q, rd_ready_q, fdone_q;
    logic                   err_ovf_q, err_unf_q, err_seq_q;
    logic                   err_ovf_d, err_unf_d, err_seq_d;
    logic                   cons_hit, place_ok, new_ovf, new_unf, new_seq;

    function automatic logic [ADDRWIDTH-1:0] gray_next(input logic [ADDRWIDTH-1:0] g);
        logic [ADDRWIDTH-1:0] b;
        b[ADDRWIDTH-1] = g[ADDRWIDTH-1];
        for (int i = ADDRWIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        b = b + 1'b1;
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        slot_after_cons = slot_q;
        occ_d           = occ_q;
        rd_addr_d       = rd_addr_q;
        wr_exp_d        = wr_exp_q;
        cons_hit        = 1'b0;
        place_ok        = 1'b0;
        new_ovf         = 1'b0;
        new_unf         = 1'b0;
        new_seq         = 1'b0;

        case (state_q)
            ST_INIT:       state_d = ST_RUN;
            ST_FLUSH:      state_d = ST_FLUSH_DONE;
            ST_FLUSH_DONE: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_d   = ST_FLUSH;
                    slot_d    = '0;
                    occ_d     = '0;
                    rd_addr_d = '0;
                    wr_exp_d  = '0;
                end else begin
                    // Consume resolves first so a same-cycle place may reuse the freed slot.
                    if (bus.consume_valid) begin
                        cons_hit = slot_q[bus.consume_addr];
                        new_unf  = !slot_q[bus.consume_addr];
                        new_seq  = (bus.consume_addr != rd_addr_q);
                        if (cons_hit) begin
                            slot_after_cons[bus.consume_addr] = 1'b0;
                            rd_addr_d = gray_next(rd_addr_q);
                        end
                    end
                    slot_d = slot_after_cons;
                    if (bus.place_valid) begin
                        place_ok = !slot_after_cons[bus.place_addr];
                        new_ovf  = slot_after_cons[bus.place_addr];
                        if (bus.place_addr != wr_exp_q) new_seq = 1'b1;
                        if (place_ok) begin
                            slot_d[bus.place_addr] = 1'b1;
                            wr_exp_d = gray_next(wr_exp_q);
                        end
                    end
                    occ_d = occ_q + {{ADDRWIDTH{1'b0}}, place_ok} - {{ADDRWIDTH{1'b0}}, cons_hit};
                end
            end
            default:       state_d = ST_INIT;
        endcase

        // A newly raised error takes priority over a same-cycle clear.
        err_ovf_d = new_ovf | (err_ovf_q & !bus.err_clear);
        err_unf_d = new_unf | (err_unf_q & !bus.err_clear);
        err_seq_d = new_seq | (err_seq_q & !bus.err_clear);
    end

    always_ff @(posedge srff_clock or negedge srff_aresetn) begin
        if (!srff_aresetn) begin
            state_q    <= ST_INIT;
            slot_q     <= '0;
            occ_q      <= '0;
            rd_addr_q  <= '0;
            wr_exp_q   <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            allow_q    <= 1'b0;
            rd_ready_q <= 1'b0;
            fdone_q    <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
            err_seq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            occ_q      <= occ_d;
            rd_addr_q  <= rd_addr_d;
            wr_exp_q   <= wr_exp_d;
            empty_q    <= (occ_d == '0);
            full_q     <= (occ_d == FULL_CNT);
            afull_q    <= (occ_d >= AF_THRESH);
            allow_q    <= (state_d == ST_RUN) && (occ_d < AF_THRESH);
            rd_ready_q <= slot_d[rd_addr_d];
            fdone_q    <= (state_d == ST_FLUSH_DONE);
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
            err_seq_q  <= err_seq_d;
        end
    end

    assign bus.slot_unused   = slot_q;
    assign bus.occupancy     = occ_q;
    assign bus.empty         = empty_q;
    assign bus.full          = full_q;
    assign bus.almost_full   = afull_q;
    assign bus.place_allow   = allow_q;
    assign bus.next_rd_addr  = rd_addr_q;
    assign bus.rd_slot_ready = rd_ready_q;
    assign bus.flush_done    = fdone_q;
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;
    assign bus.err_sequence  = err_seq_q;
endmodule

// File: tb/tb_fifo_slot_tracker.sv
// Directed bench: an 8-bit-address tracker for ordering/flush/wrap and a
// 4-bit-address tracker for the almost-full/full/overflow boundaries.
module tb_fifo_slot_tracker;
    logic srff_clock = 1'b0;
    logic srff_aresetn = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 srff_clock = ~srff_clock;

    fifo_slot_tracker_if #(.ADDRWIDTH(8)) ia ();
    fifo_slot_tracker_if #(.ADDRWIDTH(4)) ib ();

    fifo_slot_tracker #(.ADDRWIDTH(8), .ALMOST_FULL_MARGIN(10)) dut_a (
        .srff_clock  (srff_clock),
        .srff_aresetn(srff_aresetn),
        .bus         (ia)
    );

    fifo_slot_tracker #(.ADDRWIDTH(4), .ALMOST_FULL_MARGIN(2)) dut_b (
        .srff_clock  (srff_clock),
        .srff_aresetn(srff_aresetn),
        .bus         (ib)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [7:0] g8(input int b);
        logic [7:0] v;
        v = 8'(b % 256);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [3:0] g4(input int b);
        logic [3:0] v;
        v = 4'(b % 16);
        return v ^ (v >> 1);
    endfunction

    task automatic a_cyc(input logic pv, input logic [7:0] pa, input logic cv,
                         input logic [7:0] ca, input logic fl, input logic ec);
        ia.place_valid   = pv;
        ia.place_addr    = pa;
        ia.consume_valid = cv;
        ia.consume_addr  = ca;
        ia.flush_req     = fl;
        ia.err_clear     = ec;
        @(posedge srff_clock);
        #1;
        ia.place_valid   = 1'b0;
        ia.consume_valid = 1'b0;
        ia.flush_req     = 1'b0;
        ia.err_clear     = 1'b0;
    endtask

    task automatic b_place(input logic [3:0] pa);
        ib.place_valid = 1'b1;
        ib.place_addr  = pa;
        @(posedge srff_clock);
        #1;
        ib.place_valid = 1'b0;
    endtask

    initial begin
        logic       saw_wrap;
        logic [7:0] prev_rd;

        ia.place_valid = 0; ia.place_addr = 0; ia.consume_valid = 0; ia.consume_addr = 0;
        ia.flush_req = 0; ia.err_clear = 0;
        ib.place_valid = 0; ib.place_addr = 0; ib.consume_valid = 0; ib.consume_addr = 0;
        ib.flush_req = 0; ib.err_clear = 0;

        // Reset values
        #12;
        chk("rst_occ",        ia.occupancy, 0);
        chk("rst_slots",      ia.slot_unused, 0);
        chk("rst_empty",      ia.empty, 1);
        chk("rst_full",       ia.full, 0);
        chk("rst_afull",      ia.almost_full, 0);
        chk("rst_allow",      ia.place_allow, 0);
        chk("rst_rdaddr",     ia.next_rd_addr, 0);
        chk("rst_rdready",    ia.rd_slot_ready, 0);
        chk("rst_fdone",      ia.flush_done, 0);
        chk("rst_errs",       {ia.err_overflow, ia.err_underflow, ia.err_sequence}, 0);
        srff_aresetn = 1'b1;
        @(posedge srff_clock);
        #1;
        chk("init_to_run_allow", ia.place_allow, 1);

        // Consume of an empty slot, then clear the sticky flag
        a_cyc(0, 0, 1, 8'h00, 0, 0);
        chk("unf_flag",   ia.err_underflow, 1);
        chk("unf_seq",    ia.err_sequence, 0);
        chk("unf_occ",    ia.occupancy, 0);
        chk("unf_rdaddr", ia.next_rd_addr, 0);
        a_cyc(0, 0, 0, 0, 0, 1);
        chk("unf_clear",  ia.err_underflow, 0);

        // Four in-order places at gray 0,1,3,2
        for (int i = 0; i < 4; i++) a_cyc(1, g8(i), 0, 0, 0, 0);
        chk("p4_occ",     ia.occupancy, 4);
        chk("p4_slots",   ia.slot_unused, 256'h0F);
        chk("p4_rdaddr",  ia.next_rd_addr, 0);
        chk("p4_rdready", ia.rd_slot_ready, 1);
        chk("p4_empty",   ia.empty, 0);
        chk("p4_errs",    {ia.err_overflow, ia.err_underflow, ia.err_sequence}, 0);

        // Consume 0,1 then place+consume gray 3 together (place expected gray 6)
        a_cyc(0, 0, 1, 8'h00, 0, 0);
        a_cyc(0, 0, 1, 8'h01, 0, 0);
        chk("c2_occ",     ia.occupancy, 2);
        chk("c2_rdaddr",  ia.next_rd_addr, 8'h03);
        a_cyc(1, 8'h03, 1, 8'h03, 0, 0);
        chk("same_slots", ia.slot_unused, 256'h0C);
        chk("same_occ",   ia.occupancy, 2);
        chk("same_ovf",   ia.err_overflow, 0);
        chk("same_seq",   ia.err_sequence, 1);
        chk("same_rdaddr", ia.next_rd_addr, 8'h02);
        a_cyc(0, 0, 0, 0, 0, 1);
        chk("seq_clear",  ia.err_sequence, 0);

        // Flush to realign addresses, then place gray 3 while gray 1 is expected
        a_cyc(0, 0, 0, 0, 1, 0);
        a_cyc(0, 0, 0, 0, 0, 0);
        a_cyc(0, 0, 0, 0, 0, 0);
        a_cyc(1, 8'h00, 0, 0, 0, 0);
        a_cyc(1, 8'h03, 0, 0, 0, 0);
        chk("oos_seq",    ia.err_sequence, 1);
        chk("oos_slots",  ia.slot_unused, 256'h09);
        chk("oos_occ",    ia.occupancy, 2);
        a_cyc(0, 0, 0, 0, 1, 0);
        chk("fl_keeps_err", ia.err_sequence, 1);
        a_cyc(0, 0, 0, 0, 0, 0);
        a_cyc(0, 0, 0, 0, 0, 1);
        chk("fl_err_clear", ia.err_sequence, 0);

        // Eight slots occupied, then flush with a place issued during FLUSH
        for (int i = 0; i < 8; i++) a_cyc(1, g8(i), 0, 0, 0, 0);
        chk("p8_occ",     ia.occupancy, 8);
        a_cyc(0, 0, 0, 0, 1, 0);
        chk("fl1_occ",    ia.occupancy, 0);
        chk("fl1_slots",  ia.slot_unused, 0);
        chk("fl1_allow",  ia.place_allow, 0);
        chk("fl1_fdone",  ia.flush_done, 0);
        chk("fl1_rdaddr", ia.next_rd_addr, 0);
        a_cyc(1, 8'h00, 0, 0, 0, 0);
        chk("fl2_fdone",  ia.flush_done, 1);
        chk("fl2_occ",    ia.occupancy, 0);
        chk("fl2_allow",  ia.place_allow, 0);
        a_cyc(0, 0, 0, 0, 0, 0);
        chk("fl3_fdone",  ia.flush_done, 0);
        chk("fl3_allow",  ia.place_allow, 1);
        chk("fl3_occ",    ia.occupancy, 0);
        chk("fl3_errs",   {ia.err_overflow, ia.err_underflow, ia.err_sequence}, 0);

        // 2*FIFODEPTH overlapped place/consume pairs across the gray wrap
        saw_wrap = 1'b0;
        prev_rd  = ia.next_rd_addr;
        for (int i = 0; i < 512; i++) begin
            a_cyc(1, g8(i), (i > 0), g8(i + 255), 0, 0);
            if (prev_rd == 8'h80 && ia.next_rd_addr == 8'h00) saw_wrap = 1'b1;
            prev_rd = ia.next_rd_addr;
        end
        a_cyc(0, 0, 1, g8(511), 0, 0);
        if (prev_rd == 8'h80 && ia.next_rd_addr == 8'h00) saw_wrap = 1'b1;
        chk("wrap_seen",   saw_wrap, 1);
        chk("wrap_occ",    ia.occupancy, 0);
        chk("wrap_rdaddr", ia.next_rd_addr, 0);
        chk("wrap_empty",  ia.empty, 1);
        chk("wrap_errs",   {ia.err_overflow, ia.err_underflow, ia.err_sequence}, 0);

        // Small tracker: almost-full at 14, full at 16, overflow on the 17th
        for (int i = 0; i < 13; i++) b_place(g4(i));
        chk("b13_afull",  ib.almost_full, 0);
        chk("b13_allow",  ib.place_allow, 1);
        b_place(g4(13));
        chk("b14_occ",    ib.occupancy, 14);
        chk("b14_afull",  ib.almost_full, 1);
        chk("b14_allow",  ib.place_allow, 0);
        b_place(g4(14));
        b_place(g4(15));
        chk("b16_full",   ib.full, 1);
        chk("b16_occ",    ib.occupancy, 16);
        chk("b16_slots",  ib.slot_unused, 256'hFFFF);
        b_place(4'h0);
        chk("b17_ovf",    ib.err_overflow, 1);
        chk("b17_occ",    ib.occupancy, 16);
        chk("b17_seq",    ib.err_sequence, 0);

        // Asynchronous reset mid-operation
        srff_aresetn = 1'b0;
        #2;
        chk("arst_occ",   ib.occupancy, 0);
        chk("arst_ovf",   ib.err_overflow, 0);
        chk("arst_full",  ib.full, 0);
        chk("arst_slots", ib.slot_unused, 0);
        chk("arst_allow", ib.place_allow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
